uart_host_seq: RTL and testbench

- Bus-master sequencer that owns the UART register port. It programs the divisor latch after reset or on request, then polls line status continuously.
- Each poll either drains a received byte into an RX stream or moves the next byte from an internal TX FIFO into the transmit holding register.
- Sits between the UART and byte-stream clients (console/boot loader), so no client does register-level UART access.

---
 rtl/uart_pkg.sv | 70 +++++++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_host_seq.sv | 154 +++++++++++++++
 tb/tb_uart_host_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART register map, LSR/LCR bit positions, sequencer states and
// the per-state bus access encoding used by uart_host_seq.
package uart_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_LCR  = 3'd3;
    localparam logic [2:0] REG_LSR  = 3'd5;

    localparam int LCR_DLA = 31;
    localparam int LSR_DR  = 8;
    localparam int LSR_THE = 14;

    typedef enum logic [2:0] {
        CFG_LCR1,
        CFG_DLL,
        CFG_DLH,
        CFG_LCR0,
        POLL,
        RX_RD,
        TX_WR
    } seq_state_e;

    typedef struct packed {
        logic [2:0]  addr;
        logic [3:0]  we;
        logic [31:0] dat;
    } bus_acc_t;

    // Bus access presented while sitting in a given state.
    function automatic bus_acc_t access_for(seq_state_e st, logic [15:0] div,
                                            logic [7:0] tx_byte);
        bus_acc_t a;
        a = '0;
        case (st)
            CFG_LCR1: begin
                a.addr         = REG_LCR;
                a.we           = 4'b1000;
                a.dat[LCR_DLA] = 1'b1;
            end
            CFG_DLL: begin
                a.addr     = REG_DATA;
                a.we       = 4'b0001;
                a.dat[7:0] = div[7:0];
            end
            CFG_DLH: begin
                a.addr      = REG_DATA;
                a.we        = 4'b0010;
                a.dat[15:8] = div[15:8];
            end
            CFG_LCR0: begin
                a.addr = REG_LCR;
                a.we   = 4'b1000;
            end
            POLL:  a.addr = REG_LSR;
            RX_RD: a.addr = REG_DATA;
            TX_WR: begin
                a.addr     = REG_DATA;
                a.we       = 4'b0001;
                a.dat[7:0] = tx_byte;
            end
            default: a = '0;
        endcase
        return a;
    endfunction

    function automatic logic is_cfg(seq_state_e st);
        return (st == CFG_LCR1) || (st == CFG_DLL) || (st == CFG_DLH) || (st == CFG_LCR0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count. When empty, a simultaneous push and
// pop passes the write data straight through and leaves the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, empty, push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = i_push & (~full | i_pop);
    assign pop_ok  = i_pop & (~empty | i_push);
    assign o_rdata = empty ? i_wdata : mem_q[rd_ptr_q];
    assign o_count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/uart_host_seq.sv
// UART register-port master: programs the divisor latch, then polls LSR and
// moves bytes between the UART and the RX stream / TX FIFO.
module uart_host_seq
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd103,
    parameter int          TXF_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cfg_stb,
    input  logic [15:0] i_cfg_div,
    output logic        o_cfg_busy,
    input  logic        i_tx_valid,
    input  logic [7:0]  i_tx_data,
    output logic        o_tx_ready,
    output logic        o_rx_valid,
    output logic [7:0]  o_rx_data,
    input  logic        i_rx_ready,
    output logic [2:0]  o_u_addr,
    output logic        o_u_stb,
    output logic [3:0]  o_u_we,
    output logic [31:0] o_u_dat_w,
    input  logic [31:0] i_u_dat_r,
    input  logic        i_u_ack
);

    localparam int CNT_W = $clog2(TXF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] TXF_FULL = CNT_W'(TXF_DEPTH);

    seq_state_e  state_q, state_d;
    logic        stb_q, stb_d;
    bus_acc_t    acc_q, acc_d;
    logic        busy_q, busy_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_div_q, pend_div_d;
    logic [15:0] cfg_div_q, cfg_div_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;

    logic             fifo_push, fifo_pop;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             bus_done, lsr_dr, lsr_the;
    logic             unused_rd;

    assign bus_done   = stb_q & i_u_ack;
    assign lsr_dr     = i_u_dat_r[LSR_DR];
    assign lsr_the    = i_u_dat_r[LSR_THE];
    assign unused_rd  = ^{i_u_dat_r[31:15], i_u_dat_r[13:9]};
    assign o_tx_ready = (fifo_count < TXF_FULL);
    assign fifo_push  = i_tx_valid & o_tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TXF_DEPTH)
    ) u_txf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_wdata (i_tx_data),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_head),
        .o_count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        cfg_div_d  = cfg_div_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        fifo_pop   = 1'b0;

        if (rx_valid_q && i_rx_ready) rx_valid_d = 1'b0;

        if (bus_done) begin
            case (state_q)
                CFG_LCR1: state_d = CFG_DLL;
                CFG_DLL:  state_d = CFG_DLH;
                CFG_DLH:  state_d = CFG_LCR0;
                CFG_LCR0: state_d = POLL;
                POLL: begin
                    if (pend_q) begin
                        state_d   = CFG_LCR1;
                        cfg_div_d = pend_div_q;
                        pend_d    = 1'b0;
                    end else if (lsr_dr && !rx_valid_q) begin
                        state_d = RX_RD;
                    end else if (lsr_the && (fifo_count != '0)) begin
                        state_d = TX_WR;
                    end
                end
                RX_RD: begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = i_u_dat_r[7:0];
                    state_d    = POLL;
                end
                TX_WR: begin
                    fifo_pop = 1'b1;
                    state_d  = POLL;
                end
                default: state_d = CFG_LCR1;
            endcase
        end

        // A new request always wins over the consume above (last wins).
        if (i_cfg_stb) begin
            pend_d     = 1'b1;
            pend_div_d = i_cfg_div;
        end

        // The first cycle after reset has no strobe; it loads the first access.
        stb_d = 1'b1;
        acc_d = acc_q;
        if (!stb_q || bus_done) acc_d = access_for(state_d, cfg_div_d, fifo_head);

        busy_d = pend_d | is_cfg(state_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= CFG_LCR1;
            stb_q      <= 1'b0;
            acc_q      <= '0;
            busy_q     <= 1'b1;
            pend_q     <= 1'b0;
            pend_div_q <= DIV_RESET;
            cfg_div_q  <= DIV_RESET;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            stb_q      <= stb_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            cfg_div_q  <= cfg_div_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign o_u_stb    = stb_q;
    assign o_u_addr   = acc_q.addr;
    assign o_u_we     = acc_q.we;
    assign o_u_dat_w  = acc_q.dat;
    assign o_cfg_busy = busy_q;
    assign o_rx_valid = rx_valid_q;
    assign o_rx_data  = rx_data_q;

endmodule

// File: tb/tb_uart_host_seq.sv
// Bench for uart_host_seq: a UART register model plus a transaction-level
// model that predicts the access stream, RX stream and TX FIFO occupancy.
module tb_uart_host_seq;

    localparam int K_CFG  = 0;
    localparam int K_POLL = 1;
    localparam int K_RX   = 2;
    localparam int K_TX   = 3;

    typedef struct {
        int          kind;
        logic [2:0]  addr;
        logic [3:0]  we;
        logic [31:0] dat;
    } acc_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cfg_stb = 1'b0;
    logic [15:0] i_cfg_div = 16'd0;
    logic        o_cfg_busy;
    logic        i_tx_valid = 1'b0;
    logic [7:0]  i_tx_data = 8'd0;
    logic        o_tx_ready;
    logic        o_rx_valid;
    logic [7:0]  o_rx_data;
    logic        i_rx_ready = 1'b0;
    logic [2:0]  o_u_addr;
    logic        o_u_stb;
    logic [3:0]  o_u_we;
    logic [31:0] o_u_dat_w;
    logic [31:0] i_u_dat_r;
    logic        i_u_ack;

    always #5 i_clk = ~i_clk;

    uart_host_seq #(.DIV_RESET(16'd103), .TXF_DEPTH(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cfg_stb(i_cfg_stb), .i_cfg_div(i_cfg_div), .o_cfg_busy(o_cfg_busy),
        .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data), .o_tx_ready(o_tx_ready),
        .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .i_rx_ready(i_rx_ready),
        .o_u_addr(o_u_addr), .o_u_stb(o_u_stb), .o_u_we(o_u_we),
        .o_u_dat_w(o_u_dat_w), .i_u_dat_r(i_u_dat_r), .i_u_ack(i_u_ack)
    );

    // UART register model: LSR flags and RBR, acked combinationally when enabled.
    bit         u_dr, u_the, ack_en;
    logic [7:0] u_rbr;
    assign i_u_ack   = o_u_stb & ack_en;
    assign i_u_dat_r = (o_u_addr == 3'd5) ? ((32'(u_dr) << 8) | (32'(u_the) << 14))
                                          : {24'd0, u_rbr};

    // Behavioural model state.
    acc_t        exp_q[$];
    acc_t        log_q[$];
    logic [7:0]  fq[$];
    logic [7:0]  tx_src[$];
    bit          started, pend, rxv;
    logic [15:0] pend_div;
    logic [7:0]  rxd;

    // Stimulus knobs (percent, cfg in per-mille) and one-shot directed hooks.
    int          p_ack, p_dr, p_the, p_tx, p_rxr, p_cfg;
    bit          set_dr, set_the, cfg_on_tx;
    logic [7:0]  set_rbr;
    logic [15:0] cfg_on_tx_div;

    int checks = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    function automatic acc_t mk(int k, logic [2:0] a, logic [3:0] w, logic [31:0] d);
        acc_t r;
        r.kind = k; r.addr = a; r.we = w; r.dat = d;
        return r;
    endfunction

    task automatic push_cfg(logic [15:0] d);
        exp_q.push_back(mk(K_CFG, 3'd3, 4'b1000, 32'h8000_0000));
        exp_q.push_back(mk(K_CFG, 3'd0, 4'b0001, {24'd0, d[7:0]}));
        exp_q.push_back(mk(K_CFG, 3'd0, 4'b0010, {16'd0, d[15:8], 8'd0}));
        exp_q.push_back(mk(K_CFG, 3'd3, 4'b1000, 32'd0));
        exp_q.push_back(mk(K_POLL, 3'd5, 4'b0000, 32'd0));
    endtask

    task automatic model_reset();
        exp_q.delete();
        fq.delete();
        tx_src.delete();
        push_cfg(16'd103);
        started = 0; pend = 0; pend_div = 16'd103; rxv = 0; rxd = 8'd0;
        u_dr = 0; u_the = 0; u_rbr = 8'd0; ack_en = 0;
        set_dr = 0; set_the = 0; cfg_on_tx = 0;
        i_cfg_stb = 0; i_tx_valid = 0; i_rx_ready = 0;
    endtask

    function automatic int count_kind(int from, int k);
        int n = 0;
        for (int i = from; i < log_q.size(); i++) if (log_q[i].kind == k) n++;
        return n;
    endfunction

    function automatic int find_kind(int from, int k);
        for (int i = from; i < log_q.size(); i++) if (log_q[i].kind == k) return i;
        return -1;
    endfunction

    task automatic check_acc(string name, int idx, int k, logic [2:0] a, logic [3:0] w,
                             logic [31:0] d);
        if (idx < 0 || idx >= log_q.size()) begin
            timeout_fail(name);
        end else begin
            check({name, "_kind"}, log_q[idx].kind, k);
            check({name, "_addr"}, log_q[idx].addr, a);
            check({name, "_we"},   log_q[idx].we, w);
            check({name, "_dat"},  log_q[idx].dat, d);
        end
    endtask

    task automatic compare();
        acc_t h;
        h = exp_q[0];
        check("u_stb",    o_u_stb, started);
        check("u_addr",   o_u_addr, started ? h.addr : 3'd0);
        check("u_we",     o_u_we, started ? h.we : 4'd0);
        check("u_dat_w",  o_u_dat_w, started ? h.dat : 32'd0);
        check("cfg_busy", o_cfg_busy, pend || (h.kind == K_CFG));
        check("rx_valid", o_rx_valid, rxv);
        check("rx_data",  o_rx_data, rxd);
        check("tx_ready", o_tx_ready, fq.size() < 8);
    endtask

    // One clock: compare at the falling edge, drive inputs, then advance the
    // model across the coming rising edge.
    task automatic cycle();
        acc_t h;
        bit ack, push_ok, n_pend, n_rxv;
        logic [15:0] n_div;
        logic [7:0]  n_rxd;
        @(negedge i_clk);
        compare();

        ack_en     = ($urandom_range(99) < p_ack);
        i_rx_ready = ($urandom_range(99) < p_rxr);
        i_tx_valid = (tx_src.size() > 0) && ($urandom_range(99) < p_tx);
        i_tx_data  = (tx_src.size() > 0) ? tx_src[0] : 8'($urandom);
        i_cfg_stb  = 0;
        if (cfg_on_tx && started && exp_q[0].kind == K_TX) begin
            i_cfg_stb = 1; i_cfg_div = cfg_on_tx_div; cfg_on_tx = 0;
        end else if ($urandom_range(999) < p_cfg) begin
            i_cfg_stb = 1; i_cfg_div = 16'($urandom);
        end
        if (set_dr) begin u_dr = 1; u_rbr = set_rbr; set_dr = 0; end
        if (set_the) begin u_the = 1; set_the = 0; end
        if (!u_dr && $urandom_range(99) < p_dr) begin u_dr = 1; u_rbr = 8'($urandom); end
        if (!u_the && $urandom_range(99) < p_the) u_the = 1;

        ack     = started && ack_en;
        push_ok = i_tx_valid && (fq.size() < 8);
        n_pend  = pend;
        n_div   = pend_div;
        n_rxv   = rxv && !i_rx_ready;
        n_rxd   = rxd;
        if (ack) begin
            h = exp_q.pop_front();
            log_q.push_back(h);
            case (h.kind)
                K_POLL: begin
                    if (pend) begin
                        push_cfg(pend_div);
                        n_pend = 0;
                    end else if (u_dr && !rxv) begin
                        exp_q.push_back(mk(K_RX, 3'd0, 4'b0000, 32'd0));
                        exp_q.push_back(mk(K_POLL, 3'd5, 4'b0000, 32'd0));
                    end else if (u_the && fq.size() > 0) begin
                        exp_q.push_back(mk(K_TX, 3'd0, 4'b0001, {24'd0, fq[0]}));
                        exp_q.push_back(mk(K_POLL, 3'd5, 4'b0000, 32'd0));
                    end else begin
                        exp_q.push_back(mk(K_POLL, 3'd5, 4'b0000, 32'd0));
                    end
                end
                K_RX: begin n_rxv = 1; n_rxd = u_rbr; u_dr = 0; end
                K_TX: begin void'(fq.pop_front()); u_the = 0; end
                default: ;
            endcase
        end
        if (push_ok) begin
            fq.push_back(i_tx_data);
            void'(tx_src.pop_front());
        end
        if (i_cfg_stb) begin n_pend = 1; n_div = i_cfg_div; end
        pend = n_pend; pend_div = n_div; rxv = n_rxv; rxd = n_rxd;
        started = 1;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_stb"},      o_u_stb, 1'b0);
        check({tag, "_addr"},     o_u_addr, 3'd0);
        check({tag, "_we"},       o_u_we, 4'd0);
        check({tag, "_dat"},      o_u_dat_w, 32'd0);
        check({tag, "_busy"},     o_cfg_busy, 1'b1);
        check({tag, "_rx_valid"}, o_rx_valid, 1'b0);
        check({tag, "_rx_data"},  o_rx_data, 8'd0);
        check({tag, "_tx_ready"}, o_tx_ready, 1'b1);
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_rst_n = 1;
        started = 1;   // first rising edge only loads the first access
    endtask

    task automatic set_directed();
        p_ack = 100; p_dr = 0; p_the = 0; p_tx = 100; p_rxr = 100; p_cfg = 0;
    endtask

    initial begin
        int m, i1, i2, t, r;
        set_directed();
        model_reset();
        #12;
        check_reset_state("reset");
        release_reset();

        // Boot: divisor programming with DIV_RESET, then LSR polling.
        p_rxr = 0;
        for (int n = 0; n < 50 && log_q.size() < 4; n++) cycle();
        cycle();
        check("busy_after_lcr0", o_cfg_busy, 1'b0);
        for (int n = 0; n < 50 && log_q.size() < 6; n++) cycle();
        check_acc("boot_lcr1", 0, K_CFG, 3'd3, 4'b1000, 32'h8000_0000);
        check_acc("boot_dll",  1, K_CFG, 3'd0, 4'b0001, 32'h0000_0067);
        check_acc("boot_dlh",  2, K_CFG, 3'd0, 4'b0010, 32'h0000_0000);
        check_acc("boot_lcr0", 3, K_CFG, 3'd3, 4'b1000, 32'h0000_0000);
        check_acc("boot_poll", 4, K_POLL, 3'd5, 4'b0000, 32'd0);
        check_acc("boot_poll2", 5, K_POLL, 3'd5, 4'b0000, 32'd0);

        // TX: two bytes, THE raised once per byte.
        p_rxr = 100;
        m = log_q.size();
        tx_src.push_back(8'h41); tx_src.push_back(8'h42);
        set_the = 1;
        for (int n = 0; n < 50 && count_kind(m, K_TX) < 1; n++) cycle();
        for (int n = 0; n < 10; n++) cycle();
        check("no_thr_write_while_the0", count_kind(m, K_TX), 1);
        set_the = 1;
        for (int n = 0; n < 50 && count_kind(m, K_TX) < 2; n++) cycle();
        i1 = find_kind(m, K_TX);
        i2 = (i1 < 0) ? -1 : find_kind(i1 + 1, K_TX);
        check_acc("tx_first", i1, K_TX, 3'd0, 4'b0001, 32'h41);
        check_acc("tx_then_poll", (i1 < 0) ? -1 : i1 + 1, K_POLL, 3'd5, 4'b0000, 32'd0);
        check_acc("tx_second", i2, K_TX, 3'd0, 4'b0001, 32'h42);

        // RX: byte held while the consumer stalls; next DR waits for handshake.
        p_rxr = 0;
        m = log_q.size();
        set_rbr = 8'h5A; set_dr = 1;
        for (int n = 0; n < 50 && !o_rx_valid; n++) cycle();
        if (!o_rx_valid) timeout_fail("rx_valid_rise");
        check("rx_data_5a", o_rx_data, 8'h5A);
        set_rbr = 8'h33; set_dr = 1;
        for (int n = 0; n < 20; n++) cycle();
        check("rx_second_not_read", count_kind(m, K_RX), 1);
        check("rx_hold_valid", o_rx_valid, 1'b1);
        check("rx_hold_data", o_rx_data, 8'h5A);
        p_rxr = 100;
        for (int n = 0; n < 50 && count_kind(m, K_RX) < 2; n++) cycle();
        cycle();
        check("rx_second_data", o_rx_data, 8'h33);
        check("rx_second_valid", o_rx_valid, 1'b1);
        for (int n = 0; n < 4; n++) cycle();

        // DR and THE together: RX wins, TX follows after one POLL.
        m = log_q.size();
        tx_src.push_back(8'h77);
        for (int n = 0; n < 20 && fq.size() < 1; n++) cycle();
        set_rbr = 8'h11; set_dr = 1; set_the = 1;
        for (int n = 0; n < 50 && count_kind(m, K_TX) < 1; n++) cycle();
        r = find_kind(m, K_RX);
        check_acc("prio_rx", r, K_RX, 3'd0, 4'b0000, 32'd0);
        check_acc("prio_poll", (r < 0) ? -1 : r + 1, K_POLL, 3'd5, 4'b0000, 32'd0);
        check_acc("prio_tx", (r < 0) ? -1 : r + 2, K_TX, 3'd0, 4'b0001, 32'h77);

        // Reconfigure while a THR write is in flight.
        m = log_q.size();
        tx_src.push_back(8'hA5);
        cfg_on_tx = 1; cfg_on_tx_div = 16'h01B2; set_the = 1;
        for (int n = 0; n < 80 && count_kind(m, K_CFG) < 4; n++) cycle();
        t = find_kind(m, K_TX);
        check_acc("rcfg_tx", t, K_TX, 3'd0, 4'b0001, 32'hA5);
        check_acc("rcfg_poll", (t < 0) ? -1 : t + 1, K_POLL, 3'd5, 4'b0000, 32'd0);
        check_acc("rcfg_lcr1", (t < 0) ? -1 : t + 2, K_CFG, 3'd3, 4'b1000, 32'h8000_0000);
        check_acc("rcfg_dll",  (t < 0) ? -1 : t + 3, K_CFG, 3'd0, 4'b0001, 32'h0000_00B2);
        check_acc("rcfg_dlh",  (t < 0) ? -1 : t + 4, K_CFG, 3'd0, 4'b0010, 32'h0000_0100);
        check_acc("rcfg_lcr0", (t < 0) ? -1 : t + 5, K_CFG, 3'd3, 4'b1000, 32'h0000_0000);

        // Fill the FIFO, then drain with the producer still pushing.
        for (int n = 0; n < 10; n++) cycle();
        m = log_q.size();
        for (int j = 0; j < 10; j++) tx_src.push_back(8'(8'h80 + j));
        for (int n = 0; n < 40 && o_tx_ready; n++) cycle();
        check("tx_ready_full", o_tx_ready, 1'b0);
        p_the = 100;
        for (int n = 0; n < 300 && (tx_src.size() > 0 || fq.size() > 0); n++) cycle();
        if (tx_src.size() > 0 || fq.size() > 0) timeout_fail("fifo_drain");
        i1 = m;
        for (int j = 0; j < 10; j++) begin
            i1 = find_kind(i1, K_TX);
            check_acc("fifo_order", i1, K_TX, 3'd0, 4'b0001, 32'(8'h80 + j));
            if (i1 >= 0) i1++;
        end

        // Randomised traffic with stretched acks.
        p_ack = 60; p_dr = 20; p_the = 30; p_tx = 50; p_rxr = 50; p_cfg = 5;
        for (int n = 0; n < 2500; n++) begin
            if (tx_src.size() < 4) tx_src.push_back(8'($urandom));
            cycle();
        end

        // Asynchronous reset mid-stream drops the strobe at once.
        @(negedge i_clk);
        #2;
        i_rst_n = 0;
        #1;
        check("stb_async_drop", o_u_stb, 1'b0);
        model_reset();
        @(negedge i_clk);
        check_reset_state("midreset");
        release_reset();
        for (int n = 0; n < 2000; n++) begin
            if (tx_src.size() < 4) tx_src.push_back(8'($urandom));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
